// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin scheduler sharing one 8-bit ALU between NUM_REQ requesters
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_opa,
  input  logic [8*NUM_REQ-1:0] req_opb,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic [7:0]           alu_operanda,
  output logic [7:0]           alu_operandb,
  output logic [2:0]           alu_op,
  input  logic [7:0]           alu_result,
  input  logic                 alu_zero,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [7:0]           rsp_data,
  output logic                 rsp_zero,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_found;
  logic [PTR_W:0]   scan;
  logic [PTR_W+1:0] op_base;
  logic [7:0]       opa_q;
  logic [7:0]       opb_q;
  logic [2:0]       op_q;

  // Search from rr_ptr upward, wrapping at NUM_REQ so unused indices are never reached.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan >= (PTR_W+1)'(NUM_REQ)) scan = scan - (PTR_W+1)'(NUM_REQ);
      if (!pick_found && req_valid[scan[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan[PTR_W-1:0];
      end
    end
  end

  assign op_base   = (PTR_W+2)'(pick_idx) * (PTR_W+2)'(3);
  assign req_ready = (state == S_IDLE && pick_found) ? (NUM_REQ'(1) << pick_idx) : '0;
  assign rsp_valid = (state == S_RESP) ? (NUM_REQ'(1) << grant) : '0;
  assign busy      = (state != S_IDLE);

  assign alu_operanda = opa_q;
  assign alu_operandb = opb_q;
  assign alu_op       = op_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            opa_q <= req_opa[{pick_idx, 3'b000} +: 8];
            opb_q <= req_opb[{pick_idx, 3'b000} +: 8];
            op_q  <= req_op[op_base +: 3];
            grant <= pick_idx;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data <= alu_result;
          rsp_zero <= alu_zero;
          state    <= S_RESP;
        end
        S_RESP: begin
          // The served requester drops to lowest priority for the next arbitration.
          if (rsp_ready[grant]) begin
            rr_ptr <= (grant == PTR_W'(NUM_REQ-1)) ? '0 : grant + PTR_W'(1);
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural scheduling model
module tb_alu_arbiter;

  localparam int N  = 4;
  localparam int PW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [8*N-1:0] req_opa;
  logic [8*N-1:0] req_opb;
  logic [3*N-1:0] req_op;
  logic [7:0]     alu_operanda;
  logic [7:0]     alu_operandb;
  logic [2:0]     alu_op;
  logic [7:0]     alu_result;
  logic           alu_zero;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [7:0]     rsp_data;
  logic           rsp_zero;
  logic           busy;

  int checks   = 0;
  int failures = 0;
  int model_ptr = 0;

  alu_arbiter #(.NUM_REQ(N), .PTR_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_op(req_op),
    .alu_operanda(alu_operanda), .alu_operandb(alu_operandb), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a | b);
      3'd4:    return a + b;
      3'd5:    return a - b;
      3'd6:    return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  // Shared ALU instance the arbiter drives.
  assign alu_result = alu_f(alu_op, alu_operanda, alu_operandb);
  assign alu_zero   = (alu_result == 8'h00);

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (v[i[PW-1:0]]) return i;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_opa[8*r +: 8] = a;
    req_opb[8*r +: 8] = b;
    req_op[3*r +: 3]  = op;
  endtask

  task automatic test_reset();
    req_valid = '0; rsp_ready = '0; req_opa = '0; req_opb = '0; req_op = '0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    checks++; if (alu_operanda !== 8'h00 || alu_operandb !== 8'h00 || alu_op !== 3'd0) begin
      failures++; $display("FAIL reset_alu got=%h/%h/%0d exp=00/00/0", alu_operanda, alu_operandb, alu_op); end
    checks++; if (rsp_data !== 8'h00 || rsp_zero !== 1'b0) begin
      failures++; $display("FAIL reset_rsp got=%h/%b exp=00/0", rsp_data, rsp_zero); end
    model_ptr = 0;
  endtask

  task automatic test_single();
    set_req(0, 8'h0F, 8'hF0, 3'b001);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    step();
    req_valid = '0;
    #1;
    checks++; if (busy !== 1'b1 || rsp_valid !== 4'b0) begin
      failures++; $display("FAIL single_exec got busy=%b rsp_valid=%b exp 1/0000", busy, rsp_valid); end
    checks++; if (alu_operanda !== 8'h0F || alu_operandb !== 8'hF0 || alu_op !== 3'b001) begin
      failures++; $display("FAIL single_alu got=%h/%h/%0d exp=0f/f0/1", alu_operanda, alu_operandb, alu_op); end
    step();
    checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL single_rsp_valid got=%b exp=0001", rsp_valid); end
    checks++; if (rsp_data !== 8'hFF || rsp_zero !== 1'b0) begin
      failures++; $display("FAIL single_rsp_data got=%h/%b exp=ff/0", rsp_data, rsp_zero); end
    rsp_ready = 4'b0001;
    step();
    rsp_ready = '0;
    model_ptr = 1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_done_busy got=%b exp=0", busy); end
  endtask

  task automatic test_zero_flag();
    logic [7:0] ta [2] = '{8'h05, 8'hFF};
    logic [7:0] tb [2] = '{8'h05, 8'h01};
    logic [2:0] top [2] = '{3'b101, 3'b100};
    for (int t = 0; t < 2; t++) begin
      set_req(2, ta[t], tb[t], top[t]);
      req_valid = 4'b0100;
      #1;
      checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL zero_ready_%0d got=%b exp=0100", t, req_ready); end
      step();
      req_valid = '0;
      step();
      checks++; if (rsp_valid !== 4'b0100) begin failures++; $display("FAIL zero_rsp_valid_%0d got=%b exp=0100", t, rsp_valid); end
      checks++; if (rsp_data !== 8'h00 || rsp_zero !== 1'b1) begin
        failures++; $display("FAIL zero_rsp_%0d got=%h/%b exp=00/1", t, rsp_data, rsp_zero); end
      rsp_ready = 4'b0100;
      step();
      rsp_ready = '0;
      model_ptr = 3;
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d [$];
    int exp_g [$];
    int n_acc = 0, n_rsp = 0, last_rsp = 0, cyc = 0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    model_ptr = 0;
    for (int r = 0; r < N; r++) set_req(r, 8'($urandom), 8'($urandom), 3'($urandom));
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    while (n_rsp < 6 && cyc < 40) begin
      #1;
      checks++; if ($countones(rsp_valid) > 1) begin failures++; $display("FAIL rr_onehot got=%b exp=at most one bit", rsp_valid); end
      if (req_ready != '0) begin
        int g = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        checks++; if (g != n_acc % N) begin failures++; $display("FAIL rr_grant_%0d got=%0d exp=%0d", n_acc, g, n_acc % N); end
        exp_g.push_back(n_acc % N);
        exp_d.push_back(alu_f(req_op[3*(n_acc%N) +: 3], req_opa[8*(n_acc%N) +: 8], req_opb[8*(n_acc%N) +: 8]));
        n_acc++;
      end
      if (rsp_valid != '0 && exp_g.size() > 0) begin
        int eg = exp_g.pop_front();
        logic [7:0] ed = exp_d.pop_front();
        checks++; if (rsp_valid !== (4'b0001 << eg) || rsp_data !== ed) begin
          failures++; $display("FAIL rr_rsp_%0d got=%b/%h exp=%b/%h", n_rsp, rsp_valid, rsp_data, 4'b0001 << eg, ed); end
        if (n_rsp > 0) begin
          checks++; if (cyc - last_rsp != 3) begin failures++; $display("FAIL rr_spacing got=%0d exp=3", cyc - last_rsp); end
        end
        last_rsp = cyc;
        n_rsp++;
      end
      step();
      cyc++;
    end
    req_valid = '0;
    rsp_ready = '0;
    checks++; if (n_rsp != 6) begin failures++; $display("FAIL rr_count got=%0d exp=6", n_rsp); end
    model_ptr = 2;
  endtask

  task automatic test_backpressure();
    rsp_ready = '0;
    set_req(1, 8'hAA, 8'h0F, 3'b000);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_ready got=%b exp=0010", req_ready); end
    step();
    set_req(0, 8'h33, 8'h44, 3'b100);
    req_valid = 4'b0001;
    rsp_ready = 4'b0001;
    step();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (rsp_valid !== 4'b0010 || rsp_data !== 8'h0A) begin
        failures++; $display("FAIL bp_hold_rsp_%0d got=%b/%h exp=0010/0a", c, rsp_valid, rsp_data); end
      checks++; if (alu_operanda !== 8'hAA || alu_operandb !== 8'h0F || alu_op !== 3'b000) begin
        failures++; $display("FAIL bp_hold_alu_%0d got=%h/%h/%0d exp=aa/0f/0", c, alu_operanda, alu_operandb, alu_op); end
      checks++; if (req_ready !== 4'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL bp_hold_ctl_%0d got ready=%b busy=%b exp 0000/1", c, req_ready, busy); end
      step();
    end
    rsp_ready = 4'b0011;
    step();
    rsp_ready = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_next_grant got=%b exp=0001", req_ready); end
    step();
    req_valid = '0;
    step();
    checks++; if (rsp_valid !== 4'b0001 || rsp_data !== 8'h77) begin
      failures++; $display("FAIL bp_next_rsp got=%b/%h exp=0001/77", rsp_valid, rsp_data); end
    step();
    rsp_ready = '0;
    model_ptr = 1;
  endtask

  task automatic test_reset_mid();
    set_req(3, 8'h12, 8'h34, 3'b010);
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL rmid_ready got=%b exp=1000", req_ready); end
    step();
    req_valid = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (rsp_valid !== 4'b0 || busy !== 1'b0 || req_ready !== 4'b0) begin
      failures++; $display("FAIL rmid_state got rsp_valid=%b busy=%b ready=%b exp 0000/0/0000", rsp_valid, busy, req_ready); end
    checks++; if (alu_operanda !== 8'h00) begin failures++; $display("FAIL rmid_alu got=%h exp=00", alu_operanda); end
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rmid_ptr got=%b exp=0001", req_ready); end
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL rmid_req3_ready got=%b exp=1000", req_ready); end
    step();
    req_valid = '0;
    step();
    checks++; if (rsp_valid !== 4'b1000 || rsp_data !== 8'h26 || rsp_zero !== 1'b0) begin
      failures++; $display("FAIL rmid_req3_rsp got=%b/%h/%b exp=1000/26/0", rsp_valid, rsp_data, rsp_zero); end
    rsp_ready = 4'b1000;
    step();
    rsp_ready = '0;
    model_ptr = 0;
  endtask

  task automatic test_idle_hold();
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL idle_ctl_%0d got ready=%b rsp_valid=%b busy=%b exp 0000/0000/0", c, req_ready, rsp_valid, busy); end
      checks++; if (alu_operanda !== 8'h12 || alu_operandb !== 8'h34 || alu_op !== 3'b010) begin
        failures++; $display("FAIL idle_alu_%0d got=%h/%h/%0d exp=12/34/2", c, alu_operanda, alu_operandb, alu_op); end
      step();
    end
  endtask

  task automatic test_random();
    logic [N-1:0] pend = '0;
    logic [7:0]   pa [N];
    logic [7:0]   pb [N];
    logic [2:0]   po [N];
    logic [N-1:0] exp_v;
    logic [7:0]   exp_d = '0;
    bit txn = 0;
    int g = 0, phase = 0, served = 0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    model_ptr = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < N; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1;
          pa[r] = 8'($urandom); pb[r] = 8'($urandom); po[r] = 3'($urandom);
          set_req(r, pa[r], pb[r], po[r]);
        end
      end
      req_valid = pend;
      rsp_ready = 4'($urandom);
      #1;
      if (!txn) begin
        int e = pick(pend, model_ptr);
        exp_v = '0;
        if (e >= 0) exp_v[e[PW-1:0]] = 1'b1;
        checks++; if (req_ready !== exp_v || busy !== 1'b0 || rsp_valid !== 4'b0) begin
          failures++; $display("FAIL rand_idle_%0d got ready=%b busy=%b rsp_valid=%b exp %b/0/0000", cyc, req_ready, busy, rsp_valid, exp_v); end
        if (e >= 0) begin
          txn = 1; g = e; phase = 0;
          exp_d = alu_f(po[e], pa[e], pb[e]);
          pend[e[PW-1:0]] = 1'b0;
        end
      end else begin
        phase++;
        exp_v = '0;
        if (phase >= 2) exp_v[g[PW-1:0]] = 1'b1;
        checks++; if (req_ready !== 4'b0 || busy !== 1'b1 || rsp_valid !== exp_v) begin
          failures++; $display("FAIL rand_busy_%0d got ready=%b busy=%b rsp_valid=%b exp 0000/1/%b", cyc, req_ready, busy, rsp_valid, exp_v); end
        if (phase >= 2) begin
          checks++; if (rsp_data !== exp_d || rsp_zero !== (exp_d == 8'h00)) begin
            failures++; $display("FAIL rand_data_%0d got=%h/%b exp=%h/%b", cyc, rsp_data, rsp_zero, exp_d, exp_d == 8'h00); end
          if (rsp_ready[g[PW-1:0]]) begin
            txn = 0;
            model_ptr = (g + 1) % N;
            served++;
          end
        end
      end
      step();
    end
    req_valid = '0;
    rsp_ready = '0;
    checks++; if (served < 20) begin failures++; $display("FAIL rand_served got=%0d exp>=20", served); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_zero_flag();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_idle_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
